hh_train_sched: RTL and testbench
=================================

# hh_train_sched

Training-epoch scheduler for the two-neuron STDP pair (stimulus neuron → plastic synapse → output neuron). Each run is a programmed number of epochs. Each epoch has a presentation window, in which the block drives a stimulus current and enables learning, followed by a rest window, in which the current is zero, learning is gated off and the neurons are held at rest. During presentation windows the block counts pre- and post-synaptic spikes, and it reports completion through a start/busy/done handshake.

## Interface
- `WIDTH`, 8: stimulus current width; stimulus MSBs carry `stim_level`, LSBs are zero.
- `PRESENT_CYCLES`, 64: presentation window length in cycles; must be ≥1.
- `REST_CYCLES`, 32: rest window length in cycles; must be ≥1.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  run request; sampled only in IDLE.
- `epochs`  in  4  number of epochs; captured on start acceptance. 0 = empty run.
- `stim_level`  in  4  stimulus amplitude; captured on start acceptance.
- `spike_pre`  in  1  stimulus-neuron spike, one-cycle pulse.
- `spike_post`  in  1  output-neuron spike, one-cycle pulse.
- `stim_current`  out  WIDTH  current to stimulus neuron; equals `{stim_level_q, (WIDTH-4)'b0}` in PRESENT, 0 otherwise.
- `learn_en`  out  1  STDP update enable; 1 only in PRESENT.
- `neuron_hold`  out  1  holds both neurons at rest potential; 1 only in REST.
- `busy`  out  1  1 in PRESENT and REST.
- `done`  out  1  one-cycle pulse at end of run.
- `epoch_idx`  out  4  current epoch index, 0-based.
- `pre_count`  out  8  spike_pre count for the whole run.
- `post_count`  out  8  spike_post count for the whole run.

## Operation
- States: IDLE, PRESENT, REST, DONE. All outputs are registered or decoded directly from the state register.
- IDLE with `start`=1:
  - Capture `epochs` and `stim_level`.
  - Clear `pre_count`, `post_count`, `epoch_idx` and the phase counter.
  - Go to PRESENT if `epochs`≠0, else go to DONE.
- PRESENT:
  - Phase counter runs 0..PRESENT_CYCLES-1.
  - On the last count, reset the counter and go to REST.
- REST:
  - Phase counter runs 0..REST_CYCLES-1.
  - On the last count, go to DONE if `epoch_idx`==epochs_q-1.
  - Otherwise increment `epoch_idx` and go to PRESENT.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- `start` is ignored in PRESENT and REST; it is not queued.
- Spike counting:
  - Count only while in PRESENT.
  - `spike_pre` and `spike_post` in the same cycle each increment their own counter.
  - Both counters saturate at 255; no wrap.
  - Spikes in REST, IDLE and DONE are ignored.
- Counters and `epoch_idx` hold their final values in IDLE until the next accepted start.
- Counter width: phase counter is `$clog2` of max(PRESENT_CYCLES, REST_CYCLES), minimum 1 bit.

## Timing
- Reset (`rst_n`=0 at a clk edge), regardless of state:
  - State goes to IDLE.
  - `stim_current`=0, `learn_en`=0, `neuron_hold`=0, `busy`=0, `done`=0.
  - `epoch_idx`=0, `pre_count`=0, `post_count`=0; captured registers cleared.
- Reset mid-run aborts immediately; no `done` pulse is produced.
- Start latency: `start` high at edge k → `busy`, `learn_en` and `stim_current` valid from cycle k+1.
- Each PRESENT window is exactly PRESENT_CYCLES cycles; each REST window is exactly REST_CYCLES cycles.
- Run length for N≥1 epochs: N·(PRESENT_CYCLES+REST_CYCLES) busy cycles, then 1 DONE cycle. `start` is next accepted in the cycle after DONE.
- Empty run (`epochs`=0): `start` at edge k → `done`=1 in cycle k+1, `busy` never asserts, counters read 0.
- A spike in the last PRESENT cycle is counted. A spike in the first REST cycle is not counted.

## Configuration
- `HH_SCHED_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in PRESENT or REST → IDLE next cycle, with no `done` pulse.
  - Counters and `epoch_idx` retain their values at the abort.
  - `abort` in IDLE or DONE has no effect.
  - `abort` has priority over the phase-counter transition in the same cycle.
- Not defined: no `abort` port; a run ends only via DONE or reset.

## Test plan
- Reset: PRESENT_CYCLES=4, REST_CYCLES=2, `epochs`=1, `stim_level`=4'hA. Start, then pull `rst_n` low in cycle 3 → next cycle all outputs 0 and state IDLE; no `done`.
- Nominal run: same parameters, `epochs`=2, no spikes → `stim_current`=8'hA0 for cycles 1–4 and 7–10, `neuron_hold` for cycles 5–6 and 11–12, `done` in cycle 13, `epoch_idx` 0→1 at cycle 7.
- Counting: `spike_pre` every PRESENT cycle plus 1 spike in REST; `spike_post` coincident with 3 of the pre spikes → `pre_count`=8, `post_count`=3.
- Saturation and empty run:
  - PRESENT_CYCLES=300, `spike_pre` held high → `pre_count`=255.
  - `epochs`=0 → `done` 1 cycle after `start`, `busy`=0 throughout.
- Start while busy: pulse `start` in PRESENT and again in DONE → both ignored; run length unchanged; IDLE reached after DONE.
- Abort (with `HH_SCHED_ABORT_EN`): `abort` on the last REST cycle of epoch 0 of 2 → IDLE next cycle, no `done`, `epoch_idx`=0, counts retained.

Source files
------------

// File: rtl/hh_train_sched_if.sv
// Bundle between the STDP epoch scheduler and its controller / neuron pair.
// HH_SCHED_ABORT_EN adds the abort request.
interface hh_train_sched_if #(parameter int WIDTH = 8);
  logic             start;
  logic [3:0]       epochs;
  logic [3:0]       stim_level;
  logic             spike_pre;
  logic             spike_post;
`ifdef HH_SCHED_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] stim_current;
  logic             learn_en;
  logic             neuron_hold;
  logic             busy;
  logic             done;
  logic [3:0]       epoch_idx;
  logic [7:0]       pre_count;
  logic [7:0]       post_count;

`ifdef HH_SCHED_ABORT_EN
  modport master (output start, epochs, stim_level, spike_pre, spike_post, abort,
                  input  stim_current, learn_en, neuron_hold, busy, done,
                         epoch_idx, pre_count, post_count);
  modport slave  (input  start, epochs, stim_level, spike_pre, spike_post, abort,
                  output stim_current, learn_en, neuron_hold, busy, done,
                         epoch_idx, pre_count, post_count);
`else
  modport master (output start, epochs, stim_level, spike_pre, spike_post,
                  input  stim_current, learn_en, neuron_hold, busy, done,
                         epoch_idx, pre_count, post_count);
  modport slave  (input  start, epochs, stim_level, spike_pre, spike_post,
                  output stim_current, learn_en, neuron_hold, busy, done,
                         epoch_idx, pre_count, post_count);
`endif
endinterface

// File: rtl/hh_train_sched.sv
// Training-epoch scheduler: PRESENT/REST windows per epoch, spike counting, start/busy/done.
// Optional HH_SCHED_ABORT_EN: abort input returns a running schedule to IDLE without done.
module hh_train_sched #(
  parameter int WIDTH          = 8,
  parameter int PRESENT_CYCLES = 64,
  parameter int REST_CYCLES    = 32
) (
  input logic              clk,
  input logic              rst_n,
  hh_train_sched_if.slave  bus
);
  localparam int MAXC = (PRESENT_CYCLES > REST_CYCLES) ? PRESENT_CYCLES : REST_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] P_LAST = CW'(PRESENT_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(REST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, REST, DONE} state_t;

  state_t        state;
  logic [CW-1:0] phase;
  logic [3:0]    epochs_q;
  logic [3:0]    level_q;
  logic [3:0]    idx_q;
  logic [7:0]    pre_q;
  logic [7:0]    post_q;
  logic          abort_req;

`ifdef HH_SCHED_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      epochs_q <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      pre_q    <= '0;
      post_q   <= '0;
    end else begin
      // Spikes count on every PRESENT edge, including the last window cycle.
      if (state == PRESENT) begin
        if (bus.spike_pre  && pre_q  != 8'hFF) pre_q  <= pre_q  + 8'd1;
        if (bus.spike_post && post_q != 8'hFF) post_q <= post_q + 8'd1;
      end
      case (state)
        IDLE: if (bus.start) begin
          epochs_q <= bus.epochs;
          level_q  <= bus.stim_level;
          idx_q    <= '0;
          pre_q    <= '0;
          post_q   <= '0;
          phase    <= '0;
          state    <= (bus.epochs != 4'd0) ? PRESENT : DONE;
        end
        PRESENT: begin
          if (abort_req) begin
            state <= IDLE;
          end else if (phase == P_LAST) begin
            phase <= '0;
            state <= REST;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        REST: begin
          if (abort_req) begin
            state <= IDLE;
          end else if (phase == R_LAST) begin
            phase <= '0;
            if (idx_q == epochs_q - 4'd1) begin
              state <= DONE;
            end else begin
              idx_q <= idx_q + 4'd1;
              state <= PRESENT;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim_current = (state == PRESENT) ? {level_q, {(WIDTH-4){1'b0}}} : '0;
  assign bus.learn_en     = (state == PRESENT);
  assign bus.neuron_hold  = (state == REST);
  assign bus.busy         = (state == PRESENT) || (state == REST);
  assign bus.done         = (state == DONE);
  assign bus.epoch_idx    = idx_q;
  assign bus.pre_count    = pre_q;
  assign bus.post_count   = post_q;
endmodule

// File: tb/tb_hh_train_sched.sv
// Scoreboard bench for hh_train_sched: short-window instance (4/2) and a long-window one (300/2).
module tb_hh_train_sched;
  localparam int PA = 4;
  localparam int RA = 2;
  localparam int EP = PA + RA;

  typedef struct packed {
    logic [7:0] stim;
    logic       learn;
    logic       hold;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  logic [15:0] sb_cnt[$];

  always #5 clk = ~clk;

  hh_train_sched_if #(.WIDTH(8)) ia ();
  hh_train_sched_if #(.WIDTH(8)) ib ();

  hh_train_sched #(.WIDTH(8), .PRESENT_CYCLES(PA),  .REST_CYCLES(RA)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  hh_train_sched #(.WIDTH(8), .PRESENT_CYCLES(300), .REST_CYCLES(2))  u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  // Expected outputs c cycles after the start edge, from the nominal timeline.
  function automatic exp_t exp_at(int c, int n, logic [3:0] lvl);
    exp_t e;
    int   t;
    e = '0;
    t = c - 1;
    e.idx = (n == 0) ? 4'd0 : 4'(n - 1);
    if (c >= 1 && t < n * EP) begin
      e.idx  = 4'(t / EP);
      e.busy = 1'b1;
      if ((t % EP) < PA) begin
        e.stim  = {lvl, 4'h0};
        e.learn = 1'b1;
      end else begin
        e.hold = 1'b1;
      end
    end else if (c >= 1 && t == n * EP) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t obs_a();
    return exp_t'({ia.stim_current, ia.learn_en, ia.neuron_hold, ia.busy, ia.done, ia.epoch_idx});
  endfunction

  task automatic test_reset();
    exp_t e, o;
    repeat (2) @(negedge clk);
    o = obs_a();
    n_checks++;
    if (o !== '0) $display("FAIL reset_outputs got %h want %h", o, exp_t'('0));
    else n_pass++;
    n_checks++;
    if ({ia.pre_count, ia.post_count, ib.pre_count, ib.busy} !== 25'd0)
      $display("FAIL reset_counts got %h/%h/%h/%b want 0", ia.pre_count, ia.post_count, ib.pre_count, ib.busy);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    ia.epochs = 4'd1; ia.stim_level = 4'hA; ia.start = 1'b1;
    for (int c = 1; c <= 3; c++) sb.push_back(exp_at(c, 1, 4'hA));
    for (int c = 4; c <= 7; c++) sb.push_back('0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      ia.start = 1'b0;
      o = obs_a();
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL reset_mid_run cyc %0d got %h want %h", c, o, e);
      else n_pass++;
      if (c == 3) rst_n = 1'b0;
      if (c == 4) rst_n = 1'b1;
    end
  endtask

  task automatic test_nominal();
    exp_t e, o;
    @(negedge clk);
    ia.epochs = 4'd2; ia.stim_level = 4'hA; ia.start = 1'b1;
    for (int c = 1; c <= 14; c++) sb.push_back(exp_at(c, 2, 4'hA));
    sb_cnt.push_back(16'h0000);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      ia.start = 1'b0;
      o = obs_a();
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL nominal cyc %0d got %h want %h", c, o, e);
      else n_pass++;
    end
    n_checks++;
    if ({ia.pre_count, ia.post_count} !== sb_cnt[0])
      $display("FAIL nominal_counts got %h want %h", {ia.pre_count, ia.post_count}, sb_cnt[0]);
    else n_pass++;
    void'(sb_cnt.pop_front());
  endtask

  task automatic test_counting();
    exp_t e, o;
    logic [15:0] ec;
    @(negedge clk);
    ia.epochs = 4'd2; ia.stim_level = 4'h5; ia.start = 1'b1;
    for (int c = 1; c <= 14; c++) sb.push_back(exp_at(c, 2, 4'h5));
    sb_cnt.push_back({8'd8, 8'd3});
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      ia.start = 1'b0;
      o = obs_a();
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL counting_timeline cyc %0d got %h want %h", c, o, e);
      else n_pass++;
      // pre in every PRESENT cycle and the first REST cycle; post on cycles 1, 4, 7
      ia.spike_pre  = ((c >= 1 && c <= 5) || (c >= 7 && c <= 10));
      ia.spike_post = (c == 1 || c == 4 || c == 7);
    end
    ia.spike_pre = 1'b0; ia.spike_post = 1'b0;
    ec = sb_cnt.pop_front();
    n_checks++;
    if ({ia.pre_count, ia.post_count} !== ec)
      $display("FAIL counting got pre %0d post %0d want pre %0d post %0d", ia.pre_count, ia.post_count, ec[15:8], ec[7:0]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int c;
    int done_cyc;
    @(negedge clk);
    ib.epochs = 4'd1; ib.stim_level = 4'h3; ib.start = 1'b1; ib.spike_pre = 1'b1;
    sb_cnt.push_back({8'd255, 8'd0});
    done_cyc = -1;
    c = 0;
    while (done_cyc < 0 && c < 600) begin
      @(negedge clk);
      c++;
      ib.start = 1'b0;
      if (ib.done) done_cyc = c;
    end
    ib.spike_pre = 1'b0;
    n_checks++;
    if (done_cyc != 303) $display("FAIL sat_run_length got %0d want 303", done_cyc);
    else n_pass++;
    n_checks++;
    if ({ib.pre_count, ib.post_count} !== sb_cnt[0])
      $display("FAIL saturation got pre %0d post %0d want 255/0", ib.pre_count, ib.post_count);
    else n_pass++;
    void'(sb_cnt.pop_front());
  endtask

  task automatic test_empty();
    exp_t e, o;
    @(negedge clk);
    ia.epochs = 4'd0; ia.stim_level = 4'hF; ia.start = 1'b1;
    for (int c = 1; c <= 3; c++) sb.push_back(exp_at(c, 0, 4'hF));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ia.start = 1'b0;
      o = obs_a();
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL empty_run cyc %0d got %h want %h", c, o, e);
      else n_pass++;
    end
    n_checks++;
    if ({ia.pre_count, ia.post_count} !== 16'h0000)
      $display("FAIL empty_counts got %h want 0000", {ia.pre_count, ia.post_count});
    else n_pass++;
  endtask

  task automatic test_start_busy();
    exp_t e, o;
    @(negedge clk);
    ia.epochs = 4'd1; ia.stim_level = 4'h7; ia.start = 1'b1;
    for (int c = 1; c <= 9; c++) sb.push_back(exp_at(c, 1, 4'h7));
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      o = obs_a();
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL start_while_busy cyc %0d got %h want %h", c, o, e);
      else n_pass++;
      // retrigger with a larger epoch count during PRESENT and during DONE
      ia.start  = (c == 2 || c == 7);
      ia.epochs = 4'd3;
    end
    ia.start = 1'b0;
  endtask

`ifdef HH_SCHED_ABORT_EN
  task automatic test_abort();
    exp_t e, o;
    @(negedge clk);
    ia.epochs = 4'd2; ia.stim_level = 4'h9; ia.start = 1'b1;
    for (int c = 1; c <= 6; c++) sb.push_back(exp_at(c, 2, 4'h9));
    for (int c = 7; c <= 9; c++) sb.push_back('0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      ia.start = 1'b0;
      o = obs_a();
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL abort cyc %0d got %h want %h", c, o, e);
      else n_pass++;
      ia.spike_pre = (c == 2);
      ia.abort     = (c == 6);
    end
    ia.abort = 1'b0;
    n_checks++;
    if ({ia.pre_count, ia.post_count} !== {8'd1, 8'd0})
      $display("FAIL abort_counts got %h want 0100", {ia.pre_count, ia.post_count});
    else n_pass++;
  endtask
`endif

  initial begin
    ia.start = 1'b0; ia.epochs = '0; ia.stim_level = '0; ia.spike_pre = 1'b0; ia.spike_post = 1'b0;
    ib.start = 1'b0; ib.epochs = '0; ib.stim_level = '0; ib.spike_pre = 1'b0; ib.spike_post = 1'b0;
`ifdef HH_SCHED_ABORT_EN
    ia.abort = 1'b0; ib.abort = 1'b0;
`endif
    test_reset();
    test_nominal();
    test_counting();
    test_saturation();
    test_empty();
    test_start_busy();
`ifdef HH_SCHED_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
